rv32_inst_decoder: RTL and testbench
====================================

Name: rv32_inst_decoder

Overview:
- RV32I + M + Zicsr instruction decoder of the ysyx_24080006 core ID stage.
- Purely combinational decode of a 32-bit instruction into register addresses, immediate and control fields; the ID stage latches the outputs on handshake.
- A small clocked part holds a sticky illegal-instruction flag and optional instruction-class counters.

Parameters:
- REG_WIDTH, 5, register address width; 4 selects RV32E (x16–x31 illegal).

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- inst  in  32  instruction word
- dec_valid  in  1  inst is a real issued instruction; qualifies clocked state only
- rs1_addr / rs2_addr / rd_addr  out  REG_WIDTH  inst[19:15] / [24:20] / [11:7], truncated to REG_WIDTH
- rd_we  out  1  writes rd (forced 0 when rd==0 or inst_err)
- imm  out  32  sign-extended I/S/B/U/J immediate, else 0
- alu_op  out  4  ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9
- src_a_sel  out  2  0 rs1, 1 pc, 2 zero
- src_b_sel  out  1  0 rs2, 1 imm
- is_load, is_store  out  1 each
- mem_size  out  2  funct3[1:0] for load/store
- mem_unsigned  out  1  funct3[2] for load
- is_branch  out  1; br_func3  out  3  funct3
- is_jal, is_jalr  out  1 each
- is_md  out  1  M extension; md_op  out  3  funct3
- is_csr  out  1; csr_op  out  2  funct3[1:0]; csr_imm  out  1  funct3[2]; csr_addr  out  12  inst[31:20]
- is_ecall, is_ebreak, is_mret  out  1 each
- fencei  out  1  FENCE.I
- inst_err  out  1  illegal instruction
- err_seen  out  1  sticky registered illegal flag

Behaviour:
- All decode outputs are combinational from inst; zero latency. With inst_err=1, every control flag is 0 (rd_we, is_*, fencei); addresses and imm are still driven.
- LUI: src_a zero, src_b imm, ADD. AUIPC: src_a pc, src_b imm, ADD. JAL/JALR: imm J/I, rd_we, alu ADD with src_a pc (link computed by execute).
- OP_IMM: funct3 maps to ADD/SLL/SLT/SLTU/XOR/SRL-SRA/OR/AND. funct7 must be 0 for SLLI/SRLI and 0x20 for SRAI; otherwise illegal.
- OP: funct7 0x00 normal, 0x20 only for ADD→SUB and SRL→SRA, 0x01 → is_md; anything else illegal.
- LOAD: funct3 in {0,1,2,4,5}. STORE: funct3 in {0,1,2}. BRANCH: funct3 not 2 or 3. Any other funct3 is illegal.
- MISC_MEM: funct3 0 → NOP (legal, no flags); funct3 1 → fencei=1; other funct3 illegal.
- SYSTEM, funct3=0: 0x00000073 ecall, 0x00100073 ebreak, 0x30200073 mret, else illegal. SYSTEM, funct3 in {1,2,3,5,6,7}: is_csr; funct3=4 illegal.
- Any inst[1:0]!=2'b11 or unknown opcode is illegal.
- REG_WIDTH=4: any used register field with bit 4 set is illegal.
- err_seen: set at clock edge when dec_valid && inst_err. Cleared only by reset (asynchronously to 0). Simultaneous reset wins.

Optional Feature:
- INST_CNT_EN defined: five 32-bit counters (cnt_alu, cnt_mem, cnt_sys, cnt_br, cnt_jmp) as extra outputs.
  - Increment on clock when dec_valid && !inst_err, by class: LUI/AUIPC/OP/OP_IMM; LOAD/STORE; SYSTEM; BRANCH; JAL/JALR.
  - Wrap at 2^32; reset to 0.
- INST_CNT_EN undefined: counters and ports absent; all other behaviour identical.

Test Plan:
- inst=0xFFF10093 (addi x1,x2,-1) → rs1=2, rd=1, imm=0xFFFFFFFF, alu_op=0, src_b=1, rd_we=1, inst_err=0.
- inst=0x123452B7 (lui x5) → imm=0x12345000, src_a=2, rd=5, rd_we=1; inst=0x0020A423 (sw x2,8(x1)) → is_store, mem_size=2, imm=8, rd_we=0.
- inst=0xFE000EE3 (beq x0,x0,-4) → is_branch, br_func3=0, imm=0xFFFFFFFC; inst=0x0000100F → fencei=1, inst_err=0.
- inst=0x00100073 → is_ebreak=1; 0x30200073 → is_mret=1; 0x02208033 (mul) → is_md=1, md_op=0.
- inst=0x00000000 with dec_valid=1 → inst_err=1, rd_we=0, err_seen=1 next cycle and stays set; drop reset low mid-run → err_seen=0 immediately.
- REG_WIDTH=4: inst=0x01000093 (addi x1,x0,16) → legal; inst=0x00080093 (rs1=x16) → inst_err=1. With INST_CNT_EN, 3 valid addi → cnt_alu=3.

Source files
------------

// File: rtl/rv32_inst_decoder.sv
// RV32I + M + Zicsr decoder: combinational field/control decode plus a sticky illegal flag.
// Define INST_CNT_EN to add five per-class retired-instruction counters.
module rv32_inst_decoder #(
    parameter int REG_WIDTH = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          inst,
    input  logic                 dec_valid,
    output logic [REG_WIDTH-1:0] rs1_addr,
    output logic [REG_WIDTH-1:0] rs2_addr,
    output logic [REG_WIDTH-1:0] rd_addr,
    output logic                 rd_we,
    output logic [31:0]          imm,
    output logic [3:0]           alu_op,
    output logic [1:0]           src_a_sel,
    output logic                 src_b_sel,
    output logic                 is_load,
    output logic                 is_store,
    output logic [1:0]           mem_size,
    output logic                 mem_unsigned,
    output logic                 is_branch,
    output logic [2:0]           br_func3,
    output logic                 is_jal,
    output logic                 is_jalr,
    output logic                 is_md,
    output logic [2:0]           md_op,
    output logic                 is_csr,
    output logic [1:0]           csr_op,
    output logic                 csr_imm,
    output logic [11:0]          csr_addr,
    output logic                 is_ecall,
    output logic                 is_ebreak,
    output logic                 is_mret,
    output logic                 fencei,
    output logic                 inst_err,
    output logic                 err_seen
`ifdef INST_CNT_EN
    ,
    output logic [31:0]          cnt_alu,
    output logic [31:0]          cnt_mem,
    output logic [31:0]          cnt_sys,
    output logic [31:0]          cnt_br,
    output logic [31:0]          cnt_jmp
`endif
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    function automatic logic [3:0] f3_alu(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic        w_legal, w_writes, w_use_rd, w_use_rs1, w_use_rs2, w_reg_bad;
    logic        w_load, w_store, w_branch, w_jal, w_jalr, w_md, w_csr;
    logic        w_ecall, w_ebreak, w_mret, w_fencei;

    assign w_opcode = inst[6:0];
    assign w_f3     = inst[14:12];
    assign w_f7     = inst[31:25];

    assign w_imm_i = {{20{inst[31]}}, inst[31:20]};
    assign w_imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign w_imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign w_imm_u = {inst[31:12], 12'b0};
    assign w_imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        w_legal   = 1'b0;
        w_writes  = 1'b0;
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_load    = 1'b0;
        w_store   = 1'b0;
        w_branch  = 1'b0;
        w_jal     = 1'b0;
        w_jalr    = 1'b0;
        w_md      = 1'b0;
        w_csr     = 1'b0;
        w_ecall   = 1'b0;
        w_ebreak  = 1'b0;
        w_mret    = 1'b0;
        w_fencei  = 1'b0;
        imm       = 32'd0;
        alu_op    = ALU_ADD;
        src_a_sel = 2'd0;
        src_b_sel = 1'b0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_legal   = 1'b1;
                w_writes  = 1'b1;
                w_use_rd  = 1'b1;
                imm       = w_imm_u;
                src_a_sel = (w_opcode == OPC_LUI) ? 2'd2 : 2'd1;
                src_b_sel = 1'b1;
            end
            OPC_JAL: begin
                w_legal   = 1'b1;
                w_writes  = 1'b1;
                w_use_rd  = 1'b1;
                w_jal     = 1'b1;
                imm       = w_imm_j;
                src_a_sel = 2'd1;
                src_b_sel = 1'b1;
            end
            OPC_JALR: begin
                w_legal   = 1'b1;
                w_writes  = 1'b1;
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_jalr    = 1'b1;
                imm       = w_imm_i;
                src_a_sel = 2'd1;
                src_b_sel = 1'b1;
            end
            OPC_BRANCH: begin
                w_legal   = (w_f3 != 3'd2) && (w_f3 != 3'd3);
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_branch  = 1'b1;
                imm       = w_imm_b;
            end
            OPC_LOAD: begin
                w_legal   = (w_f3 != 3'd3) && (w_f3 != 3'd6) && (w_f3 != 3'd7);
                w_writes  = 1'b1;
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_load    = 1'b1;
                imm       = w_imm_i;
                src_b_sel = 1'b1;
            end
            OPC_STORE: begin
                w_legal   = (w_f3 <= 3'd2);
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_store   = 1'b1;
                imm       = w_imm_s;
                src_b_sel = 1'b1;
            end
            OPC_OP_IMM: begin
                w_legal   = 1'b1;
                w_writes  = 1'b1;
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                imm       = w_imm_i;
                src_b_sel = 1'b1;
                alu_op    = f3_alu(w_f3);
                // Shift-immediates reuse funct7 as an opcode extension.
                if (w_f3 == 3'd1) begin
                    w_legal = (w_f7 == 7'h00);
                end else if (w_f3 == 3'd5) begin
                    w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
                    if (w_f7 == 7'h20) alu_op = ALU_SRA;
                end
            end
            OPC_OP: begin
                w_writes  = 1'b1;
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                case (w_f7)
                    7'h00: begin
                        w_legal = 1'b1;
                        alu_op  = f3_alu(w_f3);
                    end
                    7'h20: begin
                        if (w_f3 == 3'd0) begin
                            w_legal = 1'b1;
                            alu_op  = ALU_SUB;
                        end else if (w_f3 == 3'd5) begin
                            w_legal = 1'b1;
                            alu_op  = ALU_SRA;
                        end
                    end
                    7'h01: begin
                        w_legal = 1'b1;
                        w_md    = 1'b1;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_MISC: begin
                w_legal  = (w_f3 <= 3'd1);
                w_fencei = (w_f3 == 3'd1);
            end
            OPC_SYSTEM: begin
                if (w_f3 == 3'd0) begin
                    w_ecall  = (inst == 32'h0000_0073);
                    w_ebreak = (inst == 32'h0010_0073);
                    w_mret   = (inst == 32'h3020_0073);
                    w_legal  = w_ecall || w_ebreak || w_mret;
                end else if (w_f3 != 3'd4) begin
                    // Immediate CSR forms carry a zimm in the rs1 field, not a register.
                    w_legal   = 1'b1;
                    w_csr     = 1'b1;
                    w_writes  = 1'b1;
                    w_use_rd  = 1'b1;
                    w_use_rs1 = !w_f3[2];
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_reg_bad = (REG_WIDTH == 4) &&
                       ((w_use_rd && inst[11]) || (w_use_rs1 && inst[19]) || (w_use_rs2 && inst[24]));

    assign inst_err = !w_legal || w_reg_bad;

    assign rs1_addr = inst[15 +: REG_WIDTH];
    assign rs2_addr = inst[20 +: REG_WIDTH];
    assign rd_addr  = inst[7 +: REG_WIDTH];

    assign rd_we     = w_writes && (inst[11:7] != 5'd0) && !inst_err;
    assign is_load   = w_load   && !inst_err;
    assign is_store  = w_store  && !inst_err;
    assign is_branch = w_branch && !inst_err;
    assign is_jal    = w_jal    && !inst_err;
    assign is_jalr   = w_jalr   && !inst_err;
    assign is_md     = w_md     && !inst_err;
    assign is_csr    = w_csr    && !inst_err;
    assign is_ecall  = w_ecall  && !inst_err;
    assign is_ebreak = w_ebreak && !inst_err;
    assign is_mret   = w_mret   && !inst_err;
    assign fencei    = w_fencei && !inst_err;

    assign mem_size     = ((w_opcode == OPC_LOAD) || (w_opcode == OPC_STORE)) ? w_f3[1:0] : 2'd0;
    assign mem_unsigned = (w_opcode == OPC_LOAD) && w_f3[2];
    assign br_func3     = w_f3;
    assign md_op        = w_f3;
    assign csr_op       = w_f3[1:0];
    assign csr_imm      = w_f3[2];
    assign csr_addr     = inst[31:20];

    logic r_err_seen;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err_seen <= 1'b0;
        end else if (dec_valid && inst_err) begin
            r_err_seen <= 1'b1;
        end
    end

    assign err_seen = r_err_seen;

`ifdef INST_CNT_EN
    logic        w_retire;
    logic        w_cls_alu, w_cls_mem, w_cls_sys, w_cls_br, w_cls_jmp;
    logic [31:0] r_cnt_alu, r_cnt_mem, r_cnt_sys, r_cnt_br, r_cnt_jmp;

    assign w_retire  = dec_valid && !inst_err;
    assign w_cls_alu = (w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC) ||
                       (w_opcode == OPC_OP)  || (w_opcode == OPC_OP_IMM);
    assign w_cls_mem = (w_opcode == OPC_LOAD) || (w_opcode == OPC_STORE);
    assign w_cls_sys = (w_opcode == OPC_SYSTEM);
    assign w_cls_br  = (w_opcode == OPC_BRANCH);
    assign w_cls_jmp = (w_opcode == OPC_JAL) || (w_opcode == OPC_JALR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt_alu <= 32'd0;
            r_cnt_mem <= 32'd0;
            r_cnt_sys <= 32'd0;
            r_cnt_br  <= 32'd0;
            r_cnt_jmp <= 32'd0;
        end else if (w_retire) begin
            if (w_cls_alu) r_cnt_alu <= r_cnt_alu + 32'd1;
            if (w_cls_mem) r_cnt_mem <= r_cnt_mem + 32'd1;
            if (w_cls_sys) r_cnt_sys <= r_cnt_sys + 32'd1;
            if (w_cls_br)  r_cnt_br  <= r_cnt_br  + 32'd1;
            if (w_cls_jmp) r_cnt_jmp <= r_cnt_jmp + 32'd1;
        end
    end

    assign cnt_alu = r_cnt_alu;
    assign cnt_mem = r_cnt_mem;
    assign cnt_sys = r_cnt_sys;
    assign cnt_br  = r_cnt_br;
    assign cnt_jmp = r_cnt_jmp;
`endif

endmodule

// File: tb/tb_rv32_inst_decoder.sv
// Bench for rv32_inst_decoder: RV32I (REG_WIDTH=5) and RV32E (REG_WIDTH=4) instances side by side.
module tb_rv32_inst_decoder;

    logic        clock;
    logic        reset;
    logic [31:0] inst;
    logic        dec_valid;

    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rd_we, src_b_sel, is_load, is_store, mem_unsigned, is_branch, is_jal, is_jalr;
    logic        is_md, is_csr, csr_imm, is_ecall, is_ebreak, is_mret, fencei, inst_err, err_seen;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [1:0]  src_a_sel, mem_size, csr_op;
    logic [2:0]  br_func3, md_op;
    logic [11:0] csr_addr;

    logic [3:0]  e_rs1_addr, e_rs2_addr, e_rd_addr;
    logic        e_rd_we, e_src_b_sel, e_is_load, e_is_store, e_mem_unsigned, e_is_branch, e_is_jal;
    logic        e_is_jalr, e_is_md, e_is_csr, e_csr_imm, e_is_ecall, e_is_ebreak, e_is_mret;
    logic        e_fencei, e_inst_err, e_err_seen;
    logic [31:0] e_imm;
    logic [3:0]  e_alu_op;
    logic [1:0]  e_src_a_sel, e_mem_size, e_csr_op;
    logic [2:0]  e_br_func3, e_md_op;
    logic [11:0] e_csr_addr;

`ifdef INST_CNT_EN
    logic [31:0] cnt_alu, cnt_mem, cnt_sys, cnt_br, cnt_jmp;
    logic [31:0] e_cnt_alu, e_cnt_mem, e_cnt_sys, e_cnt_br, e_cnt_jmp;
`endif

    rv32_inst_decoder #(.REG_WIDTH(5)) dut (
        .clock(clock), .reset(reset), .inst(inst), .dec_valid(dec_valid),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .rd_we(rd_we),
        .imm(imm), .alu_op(alu_op), .src_a_sel(src_a_sel), .src_b_sel(src_b_sel),
        .is_load(is_load), .is_store(is_store), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .is_branch(is_branch), .br_func3(br_func3), .is_jal(is_jal), .is_jalr(is_jalr),
        .is_md(is_md), .md_op(md_op), .is_csr(is_csr), .csr_op(csr_op), .csr_imm(csr_imm),
        .csr_addr(csr_addr), .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret),
        .fencei(fencei), .inst_err(inst_err), .err_seen(err_seen)
`ifdef INST_CNT_EN
        , .cnt_alu(cnt_alu), .cnt_mem(cnt_mem), .cnt_sys(cnt_sys), .cnt_br(cnt_br), .cnt_jmp(cnt_jmp)
`endif
    );

    rv32_inst_decoder #(.REG_WIDTH(4)) dut_e (
        .clock(clock), .reset(reset), .inst(inst), .dec_valid(dec_valid),
        .rs1_addr(e_rs1_addr), .rs2_addr(e_rs2_addr), .rd_addr(e_rd_addr), .rd_we(e_rd_we),
        .imm(e_imm), .alu_op(e_alu_op), .src_a_sel(e_src_a_sel), .src_b_sel(e_src_b_sel),
        .is_load(e_is_load), .is_store(e_is_store), .mem_size(e_mem_size), .mem_unsigned(e_mem_unsigned),
        .is_branch(e_is_branch), .br_func3(e_br_func3), .is_jal(e_is_jal), .is_jalr(e_is_jalr),
        .is_md(e_is_md), .md_op(e_md_op), .is_csr(e_is_csr), .csr_op(e_csr_op), .csr_imm(e_csr_imm),
        .csr_addr(e_csr_addr), .is_ecall(e_is_ecall), .is_ebreak(e_is_ebreak), .is_mret(e_is_mret),
        .fencei(e_fencei), .inst_err(e_inst_err), .err_seen(e_err_seen)
`ifdef INST_CNT_EN
        , .cnt_alu(e_cnt_alu), .cnt_mem(e_cnt_mem), .cnt_sys(e_cnt_sys), .cnt_br(e_cnt_br), .cnt_jmp(e_cnt_jmp)
`endif
    );

    // Flag vectors, bit order matches the F_* indices below.
    localparam int F_LOAD = 10, F_STORE = 9, F_BR = 8, F_JAL = 7, F_JALR = 6, F_MD = 5;
    localparam int F_CSR = 4, F_ECALL = 3, F_EBREAK = 2, F_MRET = 1, F_FENCEI = 0;

    logic [10:0] obs_flg, e_obs_flg;
    assign obs_flg   = {is_load, is_store, is_branch, is_jal, is_jalr, is_md, is_csr,
                        is_ecall, is_ebreak, is_mret, fencei};
    assign e_obs_flg = {e_is_load, e_is_store, e_is_branch, e_is_jal, e_is_jalr, e_is_md, e_is_csr,
                        e_is_ecall, e_is_ebreak, e_is_mret, e_fencei};

    typedef struct {
        logic        err;
        logic        rd_we;
        logic [31:0] imm;
        logic        chk_alu;
        logic        chk_sb;
        logic [3:0]  alu;
        logic [1:0]  sa;
        logic        sb;
        logic [10:0] flg;
        int          cls;    // 1 alu, 2 mem, 3 sys, 4 branch, 5 jump, 0 none
    } exp_t;

    int        n_checks;
    int        n_fail;
    logic      seen_m, seen_e;
    logic [0:0] exp_q[$];
    logic [0:0] e_exp_q[$];
    int        cnt_m[6];
    int        cnt_e[6];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (inst 0x%08h)", tag, obs, expv, inst);
        end
    endtask

    // Reference decode written from the ISA rules: immediates by signed arithmetic,
    // legality from per-opcode funct3/funct7 rules, register use per instruction format.
    function automatic exp_t ref_decode(input logic [31:0] w, input int rw);
        exp_t e;
        int   op, f3, f7, si, imm_i, imm_s, imm_b, imm_j;
        int   alu_tab[8];
        bit   legal, wr, u_rd, u_rs1, u_rs2;
        alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
        e = '{err: 1'b0, rd_we: 1'b0, imm: 32'd0, chk_alu: 1'b0, chk_sb: 1'b0,
              alu: 4'd0, sa: 2'd0, sb: 1'b0, flg: 11'd0, cls: 0};
        op = int'(w[6:0]);
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        si = $signed(w);
        imm_i = si >>> 20;
        imm_s = ((si >>> 25) << 5) | int'(w[11:7]);
        imm_b = ((si >>> 31) << 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1);
        imm_j = ((si >>> 31) << 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11) | (int'(w[30:21]) << 1);
        legal = 0; wr = 0; u_rd = 0; u_rs1 = 0; u_rs2 = 0;
        case (op)
            'h37, 'h17: begin
                legal = 1; wr = 1; u_rd = 1; e.cls = 1;
                e.imm = w & 32'hFFFF_F000;
                e.chk_alu = 1; e.chk_sb = 1; e.alu = 0; e.sb = 1;
                e.sa = (op == 'h37) ? 2'd2 : 2'd1;
            end
            'h6F: begin
                legal = 1; wr = 1; u_rd = 1; e.cls = 5; e.flg[F_JAL] = 1;
                e.imm = imm_j; e.chk_alu = 1; e.alu = 0; e.sa = 1;
            end
            'h67: begin
                legal = 1; wr = 1; u_rd = 1; u_rs1 = 1; e.cls = 5; e.flg[F_JALR] = 1;
                e.imm = imm_i; e.chk_alu = 1; e.alu = 0; e.sa = 1;
            end
            'h63: begin
                legal = !(f3 inside {2, 3}); u_rs1 = 1; u_rs2 = 1; e.cls = 4;
                e.flg[F_BR] = 1; e.imm = imm_b;
            end
            'h03: begin
                legal = f3 inside {0, 1, 2, 4, 5}; wr = 1; u_rd = 1; u_rs1 = 1; e.cls = 2;
                e.flg[F_LOAD] = 1; e.imm = imm_i;
            end
            'h23: begin
                legal = (f3 <= 2); u_rs1 = 1; u_rs2 = 1; e.cls = 2;
                e.flg[F_STORE] = 1; e.imm = imm_s;
            end
            'h13: begin
                wr = 1; u_rd = 1; u_rs1 = 1; e.cls = 1; e.imm = imm_i;
                e.chk_alu = 1; e.chk_sb = 1; e.sb = 1; e.sa = 0;
                if (f3 == 1)      begin legal = (f7 == 0); e.alu = 2; end
                else if (f3 == 5) begin legal = f7 inside {0, 32}; e.alu = (f7 == 32) ? 4'd7 : 4'd6; end
                else              begin legal = 1; e.alu = 4'(alu_tab[f3]); end
            end
            'h33: begin
                wr = 1; u_rd = 1; u_rs1 = 1; u_rs2 = 1; e.cls = 1;
                if (f7 == 1) begin
                    legal = 1; e.flg[F_MD] = 1;
                end else if (f7 == 0) begin
                    legal = 1; e.chk_alu = 1; e.chk_sb = 1; e.alu = 4'(alu_tab[f3]);
                end else if (f7 == 32) begin
                    legal = f3 inside {0, 5}; e.chk_alu = 1; e.chk_sb = 1;
                    e.alu = (f3 == 0) ? 4'd1 : 4'd7;
                end
            end
            'h0F: begin
                legal = (f3 <= 1); e.flg[F_FENCEI] = (f3 == 1);
            end
            'h73: begin
                e.cls = 3;
                if (f3 == 0) begin
                    e.flg[F_ECALL]  = (w == 32'h0000_0073);
                    e.flg[F_EBREAK] = (w == 32'h0010_0073);
                    e.flg[F_MRET]   = (w == 32'h3020_0073);
                    legal = (e.flg != 0);
                end else if (f3 != 4) begin
                    legal = 1; wr = 1; u_rd = 1; u_rs1 = (f3 < 4); e.flg[F_CSR] = 1;
                end
            end
            default: legal = 0;
        endcase
        if (rw == 4 && ((u_rd && w[11:7] >= 16) || (u_rs1 && w[19:15] >= 16) || (u_rs2 && w[24:20] >= 16)))
            legal = 0;
        e.err   = !legal;
        e.rd_we = wr && (w[11:7] != 0) && legal;
        if (!legal) e.flg = '0;
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [6:0] ops[11];
        logic [31:0] w;
        int k;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        w = $urandom;
        k = $urandom_range(0, 15);
        if (k < 11 || k > 12) begin
            w[6:0] = ops[$urandom_range(0, 10)];
            if (w[6:0] == 7'h33) begin
                case ($urandom_range(0, 3))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    2: w[31:25] = 7'h01;
                    default: ;
                endcase
            end
            if (w[6:0] == 7'h13 && (w[14:12] == 3'd1 || w[14:12] == 3'd5))
                w[31:25] = ($urandom_range(0, 2) == 0) ? 7'h00 : (($urandom_range(0, 1) == 0) ? 7'h20 : w[31:25]);
            if (w[6:0] == 7'h67) w[14:12] = 3'd0;
            if (w[6:0] == 7'h0F) w[14:12] = 3'($urandom_range(0, 3));
            if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 2))
                    0: w = 32'h0000_0073;
                    1: w = 32'h0010_0073;
                    default: w = 32'h3020_0073;
                endcase
            end
            if ($urandom_range(0, 1) == 0) begin
                w[24] = 1'b0; w[19] = 1'b0; w[11] = 1'b0;
            end
            if (k > 12) w[1:0] = 2'($urandom_range(0, 2));
        end
        return w;
    endfunction

    task automatic apply(input logic [31:0] w, input logic v);
        exp_t em, ee;
        @(posedge clock);
        #1;
        inst = w;
        dec_valid = v;
        @(negedge clock);
        check_eq("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) check_eq("err_seen", 32'(err_seen), 32'(exp_q.pop_front()));
        if (e_exp_q.size() != 0) check_eq("e_err_seen", 32'(e_err_seen), 32'(e_exp_q.pop_front()));
`ifdef INST_CNT_EN
        check_eq("cnt_alu", cnt_alu, 32'(cnt_m[1]));
        check_eq("cnt_mem", cnt_mem, 32'(cnt_m[2]));
        check_eq("cnt_sys", cnt_sys, 32'(cnt_m[3]));
        check_eq("cnt_br", cnt_br, 32'(cnt_m[4]));
        check_eq("cnt_jmp", cnt_jmp, 32'(cnt_m[5]));
        check_eq("e_cnt_alu", e_cnt_alu, 32'(cnt_e[1]));
        check_eq("e_cnt_mem", e_cnt_mem, 32'(cnt_e[2]));
        check_eq("e_cnt_sys", e_cnt_sys, 32'(cnt_e[3]));
        check_eq("e_cnt_br", e_cnt_br, 32'(cnt_e[4]));
        check_eq("e_cnt_jmp", e_cnt_jmp, 32'(cnt_e[5]));
`endif
        em = ref_decode(w, 5);
        ee = ref_decode(w, 4);
        check_eq("inst_err", 32'(inst_err), 32'(em.err));
        check_eq("rd_we", 32'(rd_we), 32'(em.rd_we));
        check_eq("flags", 32'(obs_flg), 32'(em.flg));
        check_eq("imm", imm, em.imm);
        check_eq("rs1_addr", 32'(rs1_addr), 32'(w[19:15]));
        check_eq("rs2_addr", 32'(rs2_addr), 32'(w[24:20]));
        check_eq("rd_addr", 32'(rd_addr), 32'(w[11:7]));
        if (em.chk_alu && !em.err) begin
            check_eq("alu_op", 32'(alu_op), 32'(em.alu));
            check_eq("src_a_sel", 32'(src_a_sel), 32'(em.sa));
        end
        if (em.chk_sb && !em.err) check_eq("src_b_sel", 32'(src_b_sel), 32'(em.sb));
        if (em.flg[F_LOAD] || em.flg[F_STORE]) check_eq("mem_size", 32'(mem_size), 32'(w[13:12]));
        if (em.flg[F_LOAD]) check_eq("mem_unsigned", 32'(mem_unsigned), 32'(w[14]));
        if (em.flg[F_BR]) check_eq("br_func3", 32'(br_func3), 32'(w[14:12]));
        if (em.flg[F_MD]) check_eq("md_op", 32'(md_op), 32'(w[14:12]));
        if (em.flg[F_CSR]) begin
            check_eq("csr_op", 32'(csr_op), 32'(w[13:12]));
            check_eq("csr_imm", 32'(csr_imm), 32'(w[14]));
            check_eq("csr_addr", 32'(csr_addr), 32'(w[31:20]));
        end
        check_eq("e_inst_err", 32'(e_inst_err), 32'(ee.err));
        check_eq("e_rd_we", 32'(e_rd_we), 32'(ee.rd_we));
        check_eq("e_flags", 32'(e_obs_flg), 32'(ee.flg));
        check_eq("e_imm", e_imm, ee.imm);
        check_eq("e_rs1_addr", 32'(e_rs1_addr), 32'(w[18:15]));
        check_eq("e_rs2_addr", 32'(e_rs2_addr), 32'(w[23:20]));
        check_eq("e_rd_addr", 32'(e_rd_addr), 32'(w[10:7]));
        if (v && em.err) seen_m = 1'b1;
        if (v && ee.err) seen_e = 1'b1;
        exp_q.push_back(seen_m);
        e_exp_q.push_back(seen_e);
        if (v && !em.err) cnt_m[em.cls]++;
        if (v && !ee.err) cnt_e[ee.cls]++;
    endtask

    task automatic clear_model();
        seen_m = 1'b0;
        seen_e = 1'b0;
        exp_q.delete();
        e_exp_q.delete();
        exp_q.push_back(1'b0);
        e_exp_q.push_back(1'b0);
        for (int i = 0; i < 6; i++) begin
            cnt_m[i] = 0;
            cnt_e[i] = 0;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        inst      = 32'd0;
        dec_valid = 1'b0;
        clear_model();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("rst_err_seen", 32'(err_seen), 32'd0);
        check_eq("rst_e_err_seen", 32'(e_err_seen), 32'd0);
`ifdef INST_CNT_EN
        check_eq("rst_cnt_alu", cnt_alu, 32'd0);
`endif
        reset = 1'b1;

        apply(32'hFFF1_0093, 1'b1);
        check_eq("addi_rs1", 32'(rs1_addr), 32'd2);
        check_eq("addi_rd", 32'(rd_addr), 32'd1);
        check_eq("addi_imm", imm, 32'hFFFF_FFFF);
        check_eq("addi_alu", 32'(alu_op), 32'd0);
        check_eq("addi_srcb", 32'(src_b_sel), 32'd1);
        check_eq("addi_rd_we", 32'(rd_we), 32'd1);
        check_eq("addi_err", 32'(inst_err), 32'd0);
        apply(32'hFFF1_0093, 1'b1);
        apply(32'hFFF1_0093, 1'b1);

        apply(32'h1234_52B7, 1'b0);
`ifdef INST_CNT_EN
        check_eq("three_addi_cnt", cnt_alu, 32'd3);
`endif
        check_eq("lui_imm", imm, 32'h1234_5000);
        check_eq("lui_srca", 32'(src_a_sel), 32'd2);
        check_eq("lui_rd", 32'(rd_addr), 32'd5);
        check_eq("lui_rd_we", 32'(rd_we), 32'd1);

        apply(32'h0020_A423, 1'b1);
        check_eq("sw_store", 32'(is_store), 32'd1);
        check_eq("sw_size", 32'(mem_size), 32'd2);
        check_eq("sw_imm", imm, 32'd8);
        check_eq("sw_rd_we", 32'(rd_we), 32'd0);

        apply(32'hFE00_0EE3, 1'b1);
        check_eq("beq_branch", 32'(is_branch), 32'd1);
        check_eq("beq_f3", 32'(br_func3), 32'd0);
        check_eq("beq_imm", imm, 32'hFFFF_FFFC);

        apply(32'h0000_100F, 1'b1);
        check_eq("fencei", 32'(fencei), 32'd1);
        check_eq("fencei_err", 32'(inst_err), 32'd0);

        apply(32'h0010_0073, 1'b1);
        check_eq("ebreak", 32'(is_ebreak), 32'd1);
        apply(32'h3020_0073, 1'b1);
        check_eq("mret", 32'(is_mret), 32'd1);
        apply(32'h0220_8033, 1'b1);
        check_eq("mul_md", 32'(is_md), 32'd1);
        check_eq("mul_op", 32'(md_op), 32'd0);

        apply(32'h0100_0093, 1'b1);
        check_eq("rv32e_x0_16_legal", 32'(e_inst_err), 32'd0);
        apply(32'h0008_0093, 1'b1);
        check_eq("rv32e_x16_err", 32'(e_inst_err), 32'd1);
        check_eq("rv32i_x16_ok", 32'(inst_err), 32'd0);

        apply(32'h0000_0000, 1'b1);
        check_eq("zero_err", 32'(inst_err), 32'd1);
        check_eq("zero_rd_we", 32'(rd_we), 32'd0);
        apply(32'hFFF1_0093, 1'b0);
        check_eq("sticky_set", 32'(err_seen), 32'd1);
        apply(32'h1234_52B7, 1'b1);
        check_eq("sticky_hold", 32'(err_seen), 32'd1);

        for (int i = 0; i < 400; i++) apply(gen_inst(), 1'($urandom_range(0, 1)));

        // Asynchronous clear away from any clock edge.
        apply(32'h0000_0000, 1'b1);
        apply(32'hFFF1_0093, 1'b1);
        #2;
        dec_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("async_rst_err_seen", 32'(err_seen), 32'd0);
        check_eq("async_rst_e_err_seen", 32'(e_err_seen), 32'd0);
`ifdef INST_CNT_EN
        check_eq("async_rst_cnt_alu", cnt_alu, 32'd0);
`endif
        clear_model();
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 60; i++) apply(gen_inst(), 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
